// File: rtl/fwd_hazard_ctrl.sv
// Forwarding/hazard controller for a 6-stage pipeline: destination-tag shadow pipe, bypass selects, stalls, mult/div busy counter.
// Optional FWD_STALL_STATS_EN adds a 32-bit stall_cnt output counting issued stall cycles.
module fwd_hazard_ctrl #(
  parameter int MD_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_use_id,
  input  logic       id_rt_use_id,
  input  logic       id_rs_use_ex,
  input  logic       id_rt_use_ex,
  input  logic       id_wr_en,
  input  logic [4:0] id_wr_addr,
  input  logic [1:0] id_res_class,
  input  logic       id_md_start,
  input  logic       id_hilo_rd,
  input  logic       mem_stall,
  input  logic       flush,
  output logic       stall,
  output logic [1:0] MUX4Sel,
  output logic [1:0] MUX5Sel,
  output logic [1:0] MUX8Sel,
  output logic [1:0] MUX9Sel,
  output logic       md_busy
`ifdef FWD_STALL_STATS_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_LOAD = 2'b01;
  localparam logic [1:0] CLS_CP0  = 2'b10;
  localparam logic [1:0] CLS_NONE = 2'b11;
  localparam logic [5:0] MD_LOAD  = 6'(MD_CYCLES);

  logic       r_ex_vld, r_m1_vld, r_m2_vld, r_wb_vld;
  logic       r_ex_md, r_m1_md;
  logic [4:0] r_ex_addr, r_m1_addr, r_m2_addr, r_wb_addr;
  logic [1:0] r_ex_cls, r_m1_cls, r_m2_cls;
  logic [1:0] r_mux4, r_mux5;
  logic [5:0] r_md_cnt;

  function automatic logic hit(input logic vld, input logic [4:0] addr, input logic [4:0] src);
    return vld && (addr == src) && (src != 5'd0);
  endfunction

  function automatic logic [1:0] ex_sel(input logic u, input logic e, input logic m1, input logic m2);
    if (!u)      return 2'b00;
    else if (e)  return 2'b01;
    else if (m1) return 2'b10;
    else if (m2) return 2'b11;
    else         return 2'b00;
  endfunction

  function automatic logic [1:0] id_sel(input logic u, input logic m1, input logic m2, input logic wb);
    if (!u)      return 2'b00;
    else if (m1) return 2'b10;
    else if (m2) return 2'b11;
    else if (wb) return 2'b01;
    else         return 2'b00;
  endfunction

  logic w_rs_ex, w_rs_m1, w_rs_m2, w_rs_wb;
  logic w_rt_ex, w_rt_m1, w_rt_m2, w_rt_wb;
  logic w_ex_late, w_m1_ld, w_m1_nalu, w_m2_ld;
  logic w_haz_rs, w_haz_rt, w_haz_md;
  logic w_stall, w_adv, w_issue, w_tag_vld;

  assign w_rs_ex = hit(r_ex_vld, r_ex_addr, id_rs);
  assign w_rs_m1 = hit(r_m1_vld, r_m1_addr, id_rs);
  assign w_rs_m2 = hit(r_m2_vld, r_m2_addr, id_rs);
  assign w_rs_wb = hit(r_wb_vld, r_wb_addr, id_rs);
  assign w_rt_ex = hit(r_ex_vld, r_ex_addr, id_rt);
  assign w_rt_m1 = hit(r_m1_vld, r_m1_addr, id_rt);
  assign w_rt_m2 = hit(r_m2_vld, r_m2_addr, id_rt);
  assign w_rt_wb = hit(r_wb_vld, r_wb_addr, id_rt);

  // Classes whose result is not yet available for the consumer's stage.
  assign w_ex_late = (r_ex_cls == CLS_LOAD) || (r_ex_cls == CLS_CP0);
  assign w_m1_ld   = (r_m1_cls == CLS_LOAD);
  assign w_m1_nalu = (r_m1_cls != CLS_ALU);
  assign w_m2_ld   = (r_m2_cls == CLS_LOAD);

  assign w_haz_rs = (id_rs_use_ex && ((w_rs_ex && w_ex_late) || (w_rs_m1 && w_m1_ld))) ||
                    (id_rs_use_id && (w_rs_ex || (w_rs_m1 && w_m1_nalu) || (w_rs_m2 && w_m2_ld)));
  assign w_haz_rt = (id_rt_use_ex && ((w_rt_ex && w_ex_late) || (w_rt_m1 && w_m1_ld))) ||
                    (id_rt_use_id && (w_rt_ex || (w_rt_m1 && w_m1_nalu) || (w_rt_m2 && w_m2_ld)));
  assign w_haz_md = (id_hilo_rd || id_md_start) && md_busy;

  assign w_stall   = id_valid && !mem_stall && (w_haz_rs || w_haz_rt || w_haz_md);
  assign w_adv     = !mem_stall;
  assign w_issue   = id_valid && !w_stall && !flush;
  assign w_tag_vld = id_wr_en && (id_res_class != CLS_NONE);

  assign stall   = w_stall;
  assign MUX4Sel = r_mux4;
  assign MUX5Sel = r_mux5;
  assign MUX8Sel = id_sel(id_rs_use_id, w_rs_m1, w_rs_m2, w_rs_wb);
  assign MUX9Sel = id_sel(id_rt_use_id, w_rt_m1, w_rt_m2, w_rt_wb);
  assign md_busy = (r_md_cnt != 6'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_vld <= 1'b0;
      r_m1_vld <= 1'b0;
      r_m2_vld <= 1'b0;
      r_wb_vld <= 1'b0;
      r_ex_md  <= 1'b0;
      r_m1_md  <= 1'b0;
      r_mux4   <= 2'b00;
      r_mux5   <= 2'b00;
    end else if (w_adv) begin
      r_ex_vld <= w_issue && w_tag_vld;
      r_ex_md  <= w_issue && id_md_start;
      r_m1_vld <= r_ex_vld && !flush;
      r_m1_md  <= r_ex_md && !flush;
      r_m2_vld <= r_m1_vld && !flush;
      r_wb_vld <= r_m2_vld;
      r_mux4   <= w_issue ? ex_sel(id_rs_use_ex, w_rs_ex, w_rs_m1, w_rs_m2) : 2'b00;
      r_mux5   <= w_issue ? ex_sel(id_rt_use_ex, w_rt_ex, w_rt_m1, w_rt_m2) : 2'b00;
    end else if (flush) begin
      r_ex_vld <= 1'b0;
      r_m1_vld <= 1'b0;
      r_ex_md  <= 1'b0;
      r_m1_md  <= 1'b0;
      r_mux4   <= 2'b00;
      r_mux5   <= 2'b00;
    end
  end

  // Tag payload carries no reset; the valid bits above qualify it.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_ex_addr <= id_wr_addr;
      r_ex_cls  <= id_res_class;
      r_m1_addr <= r_ex_addr;
      r_m1_cls  <= r_ex_cls;
      r_m2_addr <= r_m1_addr;
      r_m2_cls  <= r_m1_cls;
      r_wb_addr <= r_m2_addr;
    end
  end

  // The counter runs through mem_stall; a flush only cancels it while its mult/div is still killable.
  always_ff @(posedge clk) begin
    if (rst)
      r_md_cnt <= 6'd0;
    else if (flush && (r_ex_md || r_m1_md))
      r_md_cnt <= 6'd0;
    else if (w_adv && w_issue && id_md_start)
      r_md_cnt <= MD_LOAD;
    else if (r_md_cnt != 6'd0)
      r_md_cnt <= r_md_cnt - 6'd1;
  end

`ifdef FWD_STALL_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= 32'd0;
    else if (w_stall)
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: per-cycle vector table plus mult/div, flush and reset sequences.
module tb_fwd_hazard_ctrl;

  logic       clk, rst;
  logic       id_valid, id_rs_use_id, id_rt_use_id, id_rs_use_ex, id_rt_use_ex;
  logic       id_wr_en, id_md_start, id_hilo_rd, mem_stall, flush;
  logic [4:0] id_rs, id_rt, id_wr_addr;
  logic [1:0] id_res_class;
  logic       stall, md_busy;
  logic [1:0] MUX4Sel, MUX5Sel, MUX8Sel, MUX9Sel;
`ifdef FWD_STALL_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] sc0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  fwd_hazard_ctrl #(.MD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_use_id(id_rs_use_id), .id_rt_use_id(id_rt_use_id),
    .id_rs_use_ex(id_rs_use_ex), .id_rt_use_ex(id_rt_use_ex),
    .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_res_class(id_res_class),
    .id_md_start(id_md_start), .id_hilo_rd(id_hilo_rd), .mem_stall(mem_stall),
    .flush(flush), .stall(stall), .MUX4Sel(MUX4Sel), .MUX5Sel(MUX5Sel),
    .MUX8Sel(MUX8Sel), .MUX9Sel(MUX9Sel),
`ifdef FWD_STALL_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       rs_id, rt_id, rs_ex, rt_ex, we;
    logic [4:0] wa;
    logic [1:0] cls;
    logic       md, hl;
  } instr_t;

  typedef struct {
    instr_t     i;
    logic       ms, fl;
    logic       st;
    logic [1:0] m4, m5, m8, m9;
    logic       bz;
  } vec_t;

  vec_t vq[$];

  function automatic instr_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic rs_id, logic rt_id,
                                logic rs_ex, logic rt_ex, logic we, logic [4:0] wa, logic [1:0] cls,
                                logic md, logic hl);
    instr_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.rs_id = rs_id; r.rt_id = rt_id; r.rs_ex = rs_ex;
    r.rt_ex = rt_ex; r.we = we; r.wa = wa; r.cls = cls; r.md = md; r.hl = hl;
    return r;
  endfunction

  function automatic instr_t nop();                              return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0); endfunction
  function automatic instr_t alu(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt); return mk(1, rs, rt, 0, 0, 1, 1, 1, rd, 2'b00, 0, 0); endfunction
  function automatic instr_t lw(logic [4:0] rt, logic [4:0] base); return mk(1, base, rt, 0, 0, 1, 0, 1, rt, 2'b01, 0, 0); endfunction
  function automatic instr_t beq(logic [4:0] rs, logic [4:0] rt);  return mk(1, rs, rt, 1, 1, 0, 0, 0, 0, 2'b11, 0, 0); endfunction
  function automatic instr_t div(logic [4:0] rs, logic [4:0] rt);  return mk(1, rs, rt, 0, 0, 1, 1, 0, 0, 2'b11, 1, 0); endfunction
  function automatic instr_t mflo(logic [4:0] rd);                 return mk(1, 0, 0, 0, 0, 0, 0, 1, rd, 2'b00, 0, 1); endfunction
  function automatic instr_t mfc0(logic [4:0] rt);                 return mk(1, 0, rt, 0, 0, 0, 0, 1, rt, 2'b10, 0, 0); endfunction

  function automatic vec_t V(instr_t i, logic ms, logic fl, logic st, logic [1:0] m4, logic [1:0] m5,
                             logic [1:0] m8, logic [1:0] m9, logic bz);
    vec_t r;
    r.i = i; r.ms = ms; r.fl = fl; r.st = st; r.m4 = m4; r.m5 = m5; r.m8 = m8; r.m9 = m9; r.bz = bz;
    return r;
  endfunction

  task automatic drive(instr_t i, logic ms, logic fl);
    id_valid = i.v; id_rs = i.rs; id_rt = i.rt;
    id_rs_use_id = i.rs_id; id_rt_use_id = i.rt_id; id_rs_use_ex = i.rs_ex; id_rt_use_ex = i.rt_ex;
    id_wr_en = i.we; id_wr_addr = i.wa; id_res_class = i.cls;
    id_md_start = i.md; id_hilo_rd = i.hl; mem_stall = ms; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic nops(int n);
    for (int k = 0; k < n; k++) vq.push_back(V(nop(), 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    // ADD $8 -> SUB, then one-NOP gap to 10
    vq.push_back(V(alu(8, 1, 2),   0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(V(alu(10, 8, 3),  0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(V(nop(),          0, 0, 0, 1, 0, 0, 0, 0));
    vq.push_back(V(nop(),          0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(V(alu(11, 12, 13),0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(V(nop(),          0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(V(alu(14, 11, 0), 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(V(nop(),          0, 0, 0, 2, 0, 0, 0, 0));
    nops(3);
    // LW $9 -> ADD rt=$9: two stalls, then MUX5=11
    vq.push_back(V(lw(9, 5),       0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(V(alu(20, 6, 9),  0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(V(alu(20, 6, 9),  0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(V(alu(20, 6, 9),  0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(V(nop(),          0, 0, 0, 0, 3, 0, 0, 0));
    nops(3);
    // ADDI $4 -> BEQ: one stall then MUX8=10
    vq.push_back(V(alu(4, 1, 0),   0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(V(beq(4, 0),      0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(V(beq(4, 0),      0, 0, 0, 0, 0, 2, 0, 0));
    nops(2);
    // ADDI, NOP, then BEQs see the producer in MEM1, MEM2, WB, gone
    vq.push_back(V(alu(4, 1, 0),   0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(V(nop(),          0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(V(beq(4, 0),      0, 0, 0, 0, 0, 2, 0, 0));
    vq.push_back(V(beq(0, 4),      0, 0, 0, 0, 0, 0, 3, 0));
    vq.push_back(V(beq(4, 4),      0, 0, 0, 0, 0, 1, 1, 0));
    vq.push_back(V(beq(4, 0),      0, 0, 0, 0, 0, 0, 0, 0));
    // MFC0 -> EX consumer: one stall, then MUX4=10
    vq.push_back(V(mfc0(7),        0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(V(alu(21, 7, 0),  0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(V(alu(21, 7, 0),  0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(V(nop(),          0, 0, 0, 2, 0, 0, 0, 0));
    nops(3);
    // register 0 never forwards or stalls
    vq.push_back(V(alu(0, 1, 2),   0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(V(beq(0, 0),      0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(V(alu(3, 0, 0),   0, 0, 0, 0, 0, 0, 0, 0));
    nops(4);
    // mem_stall freeze with ADD->SUB in flight
    vq.push_back(V(alu(8, 1, 2),   0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(V(alu(10, 8, 3),  0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(V(beq(8, 0),      1, 0, 0, 1, 0, 2, 0, 0));
    vq.push_back(V(beq(10, 0),     1, 0, 0, 1, 0, 0, 0, 0));
    vq.push_back(V(beq(8, 0),      1, 0, 0, 1, 0, 2, 0, 0));
    vq.push_back(V(beq(10, 0),     0, 0, 1, 1, 0, 0, 0, 0));
    vq.push_back(V(beq(10, 0),     0, 0, 0, 0, 0, 2, 0, 0));
    nops(3);
    // flush with LW in EX
    vq.push_back(V(lw(9, 5),       0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(V(alu(20, 9, 0),  0, 1, 1, 0, 0, 0, 0, 0));
    vq.push_back(V(alu(20, 9, 0),  0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(V(nop(),          0, 0, 0, 0, 0, 0, 0, 0));
    // flush drops the issue, kills MEM1 producer, zeroes MUX4
    vq.push_back(V(alu(8, 1, 2),   0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(V(alu(10, 8, 0),  0, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(V(beq(10, 8),     0, 0, 0, 0, 0, 0, 0, 0));
    nops(3);

    rst = 1'b1;
    drive(nop(), 0, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset", {28'd0, stall, MUX4Sel, md_busy}, 32'd0);
    chk("reset_sel5", {30'd0, MUX5Sel}, 32'd0);

    for (int k = 0; k < vq.size(); k++) begin
      drive(vq[k].i, vq[k].ms, vq[k].fl);
      #1;
      chk($sformatf("vec%0d", k),
          {21'd0, stall, MUX4Sel, MUX5Sel, MUX8Sel, MUX9Sel, md_busy},
          {21'd0, vq[k].st, vq[k].m4, vq[k].m5, vq[k].m8, vq[k].m9, vq[k].bz});
      tick();
    end

    // DIV then MFLO: stall for exactly the 4 busy cycles
    drive(div(1, 2), 0, 0);
    #1;
    chk("div_issue", {30'd0, stall, md_busy}, 32'd0);
    tick();
    drive(mflo(3), 0, 0);
`ifdef FWD_STALL_STATS_EN
    sc0 = stall_cnt;
`endif
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("mflo_wait%0d", k), {30'd0, stall, md_busy}, 32'd3);
      tick();
    end
    #1;
    chk("mflo_go", {30'd0, stall, md_busy}, 32'd0);
`ifdef FWD_STALL_STATS_EN
    chk("stall_cnt", stall_cnt - sc0, 32'd4);
`endif
    tick();

    // counter keeps running through mem_stall
    drive(div(1, 2), 0, 0);
    tick();
    drive(nop(), 1, 0);
    tick();
    tick();
    drive(nop(), 0, 0);
    #1; chk("md_ms_a", {31'd0, md_busy}, 32'd1);
    tick();
    #1; chk("md_ms_b", {31'd0, md_busy}, 32'd1);
    tick();
    #1; chk("md_ms_done", {31'd0, md_busy}, 32'd0);

    // flush while the DIV is in EX cancels the count
    drive(div(1, 2), 0, 0);
    tick();
    drive(nop(), 0, 1);
    tick();
    drive(nop(), 0, 0);
    #1; chk("md_flush_ex", {31'd0, md_busy}, 32'd0);

    // flush once the DIV reached MEM2 leaves the count running
    drive(div(1, 2), 0, 0);
    tick();
    drive(nop(), 0, 0);
    tick();
    tick();
    drive(nop(), 0, 1);
    tick();
    drive(nop(), 0, 0);
    #1; chk("md_flush_m2_a", {31'd0, md_busy}, 32'd1);
    tick();
    #1; chk("md_flush_m2_b", {31'd0, md_busy}, 32'd0);
    tick();

    // reset during mem_stall with a live select, tag and count
    drive(alu(8, 1, 2), 0, 0);
    tick();
    drive(div(8, 3), 0, 0);
    tick();
    drive(nop(), 0, 0);
    #1; chk("pre_rst", {29'd0, MUX4Sel, md_busy}, 32'd3);
    rst = 1'b1;
    drive(nop(), 1, 0);
    tick();
    rst = 1'b0;
    drive(beq(8, 0), 1, 0);
    #1;
    chk("post_rst", {27'd0, MUX4Sel, MUX8Sel, md_busy}, 32'd0);
`ifdef FWD_STALL_STATS_EN
    chk("post_rst_cnt", stall_cnt, 32'd0);
`endif
    drive(nop(), 0, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
